// File: rtl/mux4x1_sched.sv
// Round-robin, burst-limited arbiter sharing one registered 4:1 byte mux among four lanes.
// Define MUX_SCHED_STATS_EN to add the beat_cnt / switch_cnt statistics outputs.
module mux4x1_sched #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        valid,
  output logic [3:0]        ready,
  output logic [DATA_W-1:0] out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [1:0]        sel,
  output logic              busy
`ifdef MUX_SCHED_STATS_EN
  ,
  output logic [15:0]       beat_cnt,
  output logic [7:0]        switch_cnt
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t            state;
  logic [1:0]        last_grant;
  logic [3:0]        burst_cnt;
  logic              bubble;
  logic              out_free;
  logic              xfer;
  logic              last_beat;
  logic              release_g;
  logic              any_valid;
  logic [1:0]        pick;
  logic [1:0]        idx;
  logic              found;
  logic [DATA_W-1:0] sel_data;

  assign out_free  = !valid_out || ready_out;
  assign any_valid = |valid;
  assign xfer      = valid[sel] && ready[sel];
  assign last_beat = xfer && (burst_cnt == BURST_LAST);
  assign release_g = last_beat || !valid[sel];

  // A burst-end rotation holds ready low for one cycle so the switch costs one bubble.
  always_comb begin
    ready = 4'b0000;
    if (busy && !bubble && out_free)
      ready[sel] = 1'b1;
  end

  always_comb begin
    case (sel)
      2'd0:    sel_data = in0;
      2'd1:    sel_data = in1;
      2'd2:    sel_data = in2;
      default: sel_data = in3;
    endcase
  end

  // Scan from last_grant+1 so the previous owner is checked last.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= 2'd0;
      last_grant <= 2'd3;
      burst_cnt  <= 4'd0;
      bubble     <= 1'b0;
      busy       <= 1'b0;
      out        <= '0;
      valid_out  <= 1'b0;
    end else begin
      if (xfer) begin
        out       <= sel_data;
        valid_out <= 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end

      bubble <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            sel        <= pick;
            last_grant <= pick;
            burst_cnt  <= 4'd0;
            state      <= GRANT;
            busy       <= 1'b1;
          end
        end
        GRANT: begin
          if (release_g) begin
            burst_cnt <= 4'd0;
            if (any_valid) begin
              sel        <= pick;
              last_grant <= pick;
              bubble     <= last_beat;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt   <= 16'd0;
      switch_cnt <= 8'd0;
    end else begin
      if (xfer && beat_cnt != 16'hFFFF)
        beat_cnt <= beat_cnt + 16'd1;
      if (state == GRANT && release_g && any_valid && pick != sel && switch_cnt != 8'hFF)
        switch_cnt <= switch_cnt + 8'd1;
    end
  end
`endif

endmodule
